// File: rtl/bmc_soft_pipe_if.sv
// Handshake bundle for the branch-metric unit: upstream beat (symbols, erasures,
// mode, frame tag) and downstream metric vector with best-hypothesis index.
interface bmc_soft_pipe_if #(
    parameter int N  = 2,
    parameter int SW = 3
);
    localparam int MW = SW + $clog2(N);
    localparam int NH = 2 ** N;

    logic              in_valid;
    logic              in_ready;
    logic [N*SW-1:0]   in_sym;
    logic [N-1:0]      in_erase;
    logic              in_hard;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [NH*MW-1:0]  out_bm;
    logic [N-1:0]      out_min_idx;
    logic              out_last;

    modport master (
        output in_valid, in_sym, in_erase, in_hard, in_last, out_ready,
        input  in_ready, out_valid, out_bm, out_min_idx, out_last
    );

    modport slave (
        input  in_valid, in_sym, in_erase, in_hard, in_last, out_ready,
        output in_ready, out_valid, out_bm, out_min_idx, out_last
    );
endinterface

// File: rtl/bmc_soft_pipe.sv
// Two-stage branch-metric unit: stage 1 registers per-symbol distances for both
// expected bits, stage 2 registers all 2**N hypothesis sums plus their argmin.
module bmc_soft_pipe #(
    parameter int N  = 2,
    parameter int SW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    bmc_soft_pipe_if.slave   bus
);
    localparam int MW = SW + $clog2(N);
    localparam int NH = 2 ** N;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic [SW-1:0]     w_d0 [N];
    logic [SW-1:0]     w_d1 [N];
    logic [MW-1:0]     w_bm [NH];
    logic [NH*MW-1:0]  w_bm_flat;
    logic [N-1:0]      w_min_idx;
    logic [MW-1:0]     w_min_val;

    logic              r_s1_valid;
    logic              r_s1_last;
    logic [SW-1:0]     r_s1_d0 [N];
    logic [SW-1:0]     r_s1_d1 [N];

    logic              r_out_valid;
    logic              r_out_last;
    logic [NH*MW-1:0]  r_out_bm;
    logic [N-1:0]      r_out_min_idx;

    // Ready is a function of registered valids and out_ready only.
    assign w_s2_adv     = !r_out_valid || bus.out_ready;
    assign w_s1_adv     = !r_s1_valid || w_s2_adv;
    assign bus.in_ready = w_s1_adv;

    // Offset-binary: SMAX - s is simply the bitwise complement of s.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dist
            logic [SW-1:0] w_sym;
            assign w_sym    = bus.in_sym[gi*SW +: SW];
            assign w_d0[gi] = bus.in_erase[gi] ? '0 :
                              bus.in_hard      ? SW'(w_sym[SW-1]) : w_sym;
            assign w_d1[gi] = bus.in_erase[gi] ? '0 :
                              bus.in_hard      ? SW'(!w_sym[SW-1]) : ~w_sym;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_s1_d0[i] <= '0;
                r_s1_d1[i] <= '0;
            end
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_last <= bus.in_last;
                for (int i = 0; i < N; i++) begin
                    r_s1_d0[i] <= w_d0[i];
                    r_s1_d1[i] <= w_d1[i];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NH; gi++) begin : g_hyp
            localparam logic [N-1:0] HYP = N'(gi);
            logic [MW-1:0] w_sum;
            always_comb begin
                w_sum = '0;
                for (int i = 0; i < N; i++) begin
                    w_sum = w_sum + MW'(HYP[i] ? r_s1_d1[i] : r_s1_d0[i]);
                end
            end
            assign w_bm[gi]               = w_sum;
            assign w_bm_flat[gi*MW +: MW] = w_sum;
        end
    endgenerate

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_min_idx = '0;
        w_min_val = w_bm[0];
        for (int h = 1; h < NH; h++) begin
            if (w_bm[h] < w_min_val) begin
                w_min_val = w_bm[h];
                w_min_idx = N'(h);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_bm      <= '0;
            r_out_min_idx <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_last    <= r_s1_last;
                r_out_bm      <= w_bm_flat;
                r_out_min_idx <= w_min_idx;
            end
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_last    = r_out_last;
    assign bus.out_bm      = r_out_bm;
    assign bus.out_min_idx = r_out_min_idx;
endmodule
